// File: rtl/pmod_cls_emul_spi_resp.sv
// SPI Mode 0 responder emulating the PMOD CLS display: 2x16 text buffer, ESC[..j / ESC[..H decode.
// Optional read-back echo of the last byte on CIPO under PMOD_CLS_RESP_ECHO_EN.
module pmod_cls_emul_spi_resp #(
   parameter int parm_sync_stages = 2,
   parameter int parm_param_max   = 99
) (
   input  logic         i_ext_spi_clk_x,
   input  logic         i_srst,
   input  logic         i_sck,
   input  logic         i_csn,
   input  logic         i_copi,
   output logic         o_cipo,
   output logic [127:0] o_line1,
   output logic [127:0] o_line2,
   output logic         o_cursor_row,
   output logic [3:0]   o_cursor_col,
   output logic         o_update,
   output logic         o_cmd_clear,
   output logic         o_err
);

   typedef enum logic [1:0] {
      ST_TEXT   = 2'd0,
      ST_ESC    = 2'd1,
      ST_PARAM1 = 2'd2,
      ST_PARAM2 = 2'd3
   } state_t;

   logic [parm_sync_stages-1:0] sck_sync, csn_sync, copi_sync;
   logic       sck_prev, csn_prev;
   logic       sck_now, csn_now, copi_now;
   logic       sck_rise, sck_fall, csn_rise, csn_fall, shift_en;
   logic [2:0] bit_cnt;
   logic [7:0] shift_reg, byte_data;
   logic       byte_strobe, abort;
   state_t     state;
   logic [6:0] param1, param2;
   logic [6:0] pos;
   logic       is_digit;

   function automatic logic [6:0] sat_param(input logic [6:0] cur, input logic [3:0] digit);
      logic [10:0] sum;
      sum = ({4'd0, cur} * 11'd10) + {7'd0, digit};
      if (sum > 11'(parm_param_max)) sat_param = 7'(parm_param_max);
      else                           sat_param = sum[6:0];
   endfunction

   always_comb begin
      sck_now  = sck_sync[parm_sync_stages-1];
      csn_now  = csn_sync[parm_sync_stages-1];
      copi_now = copi_sync[parm_sync_stages-1];
      sck_rise = sck_now & ~sck_prev;
      sck_fall = ~sck_now & sck_prev;
      csn_rise = csn_now & ~csn_prev;
      csn_fall = ~csn_now & csn_prev;
      // a rise coinciding with the CSN rise still belongs to the frame
      shift_en = sck_rise & ~(csn_now & csn_prev);
      pos      = 7'd127 - {o_cursor_col, 3'b000};
      is_digit = (byte_data >= 8'h30) && (byte_data <= 8'h39);
   end

   always_ff @(posedge i_ext_spi_clk_x) begin
      if (i_srst) begin
         sck_sync  <= {parm_sync_stages{1'b0}};
         csn_sync  <= {parm_sync_stages{1'b1}};
         copi_sync <= {parm_sync_stages{1'b0}};
         sck_prev  <= 1'b0;
         csn_prev  <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[parm_sync_stages-2:0], i_sck};
         csn_sync  <= {csn_sync[parm_sync_stages-2:0], i_csn};
         copi_sync <= {copi_sync[parm_sync_stages-2:0], i_copi};
         sck_prev  <= sck_now;
         csn_prev  <= csn_now;
      end
   end

   // byte assembly; a CSN rise with a partial byte flags an abort
   always_ff @(posedge i_ext_spi_clk_x) begin
      if (i_srst) begin
         bit_cnt     <= 3'd0;
         shift_reg   <= 8'd0;
         byte_data   <= 8'd0;
         byte_strobe <= 1'b0;
         abort       <= 1'b0;
      end else begin
         byte_strobe <= 1'b0;
         abort       <= 1'b0;
         if (shift_en) begin
            shift_reg <= {shift_reg[6:0], copi_now};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               byte_strobe <= 1'b1;
               byte_data   <= {shift_reg[6:0], copi_now};
            end
         end
         if (csn_rise) begin
            bit_cnt <= 3'd0;
            if ((bit_cnt != 3'd0) && !(shift_en && (bit_cnt == 3'd7))) abort <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_ext_spi_clk_x) begin
      if (i_srst) begin
         state        <= ST_TEXT;
         param1       <= 7'd0;
         param2       <= 7'd0;
         o_line1      <= {16{8'h20}};
         o_line2      <= {16{8'h20}};
         o_cursor_row <= 1'b0;
         o_cursor_col <= 4'd0;
         o_update     <= 1'b0;
         o_cmd_clear  <= 1'b0;
         o_err        <= 1'b0;
      end else begin
         o_update    <= 1'b0;
         o_cmd_clear <= 1'b0;
         o_err       <= abort;
         if (byte_strobe) begin
            case (state)
               ST_TEXT: begin
                  if (byte_data == 8'h1B) begin
                     state <= ST_ESC;
                  end else if ((byte_data >= 8'h20) && (byte_data <= 8'h7E)) begin
                     if (o_cursor_row == 1'b0) o_line1[pos -: 8] <= byte_data;
                     else                      o_line2[pos -: 8] <= byte_data;
                     o_update <= 1'b1;
                     if (o_cursor_col == 4'd15) begin
                        o_cursor_col <= 4'd0;
                        o_cursor_row <= ~o_cursor_row;
                     end else begin
                        o_cursor_col <= o_cursor_col + 4'd1;
                     end
                  end else begin
                     state <= ST_TEXT;
                  end
               end
               ST_ESC: begin
                  if (byte_data == 8'h5B) begin
                     state  <= ST_PARAM1;
                     param1 <= 7'd0;
                     param2 <= 7'd0;
                  end else begin
                     state <= ST_TEXT;
                     o_err <= 1'b1;
                  end
               end
               ST_PARAM1, ST_PARAM2: begin
                  if (is_digit) begin
                     if (state == ST_PARAM1) param1 <= sat_param(param1, byte_data[3:0]);
                     else                    param2 <= sat_param(param2, byte_data[3:0]);
                  end else if ((byte_data == 8'h3B) && (state == ST_PARAM1)) begin
                     state <= ST_PARAM2;
                  end else if (byte_data == 8'h6A) begin
                     state        <= ST_TEXT;
                     o_line1      <= {16{8'h20}};
                     o_line2      <= {16{8'h20}};
                     o_cursor_row <= 1'b0;
                     o_cursor_col <= 4'd0;
                     o_cmd_clear  <= 1'b1;
                  end else if (byte_data == 8'h48) begin
                     state        <= ST_TEXT;
                     o_cursor_row <= (param1 != 7'd0);
                     o_cursor_col <= (param2 > 7'd15) ? 4'd15 : param2[3:0];
                  end else begin
                     state <= ST_TEXT;
                     o_err <= 1'b1;
                  end
               end
               default: state <= ST_TEXT;
            endcase
         end
      end
   end

`ifdef PMOD_CLS_RESP_ECHO_EN
   logic [7:0] echo, tx;

   // echo holds the last complete byte; tx is the copy shifted out during a frame
   always_ff @(posedge i_ext_spi_clk_x) begin
      if (i_srst) begin
         echo   <= 8'd0;
         tx     <= 8'd0;
         o_cipo <= 1'b0;
      end else begin
         if (byte_strobe) echo <= byte_data;
         if (csn_fall) begin
            o_cipo <= echo[7];
            tx     <= {echo[6:0], 1'b0};
         end else if (sck_fall && !csn_now) begin
            o_cipo <= tx[7];
            tx     <= {tx[6:0], 1'b0};
         end else begin
            tx <= tx;
         end
      end
   end
`else
   assign o_cipo = 1'b0;
`endif

endmodule

// File: tb/tb_pmod_cls_emul_spi_resp.sv
// Self-checking bench for pmod_cls_emul_spi_resp: byte-level display model plus directed frames.
module tb_pmod_cls_emul_spi_resp;

   logic         clk = 1'b0;
   logic         srst, sck, csn, copi;
   logic         cipo, cur_row, upd, clr, err;
   logic [127:0] line1, line2;
   logic [3:0]   cur_col;

   always #5 clk = ~clk;

   pmod_cls_emul_spi_resp #(.parm_sync_stages(2), .parm_param_max(99)) dut (
      .i_ext_spi_clk_x(clk), .i_srst(srst), .i_sck(sck), .i_csn(csn), .i_copi(copi),
      .o_cipo(cipo), .o_line1(line1), .o_line2(line2), .o_cursor_row(cur_row),
      .o_cursor_col(cur_col), .o_update(upd), .o_cmd_clear(clr), .o_err(err)
   );

   int n_checks = 0, n_fail = 0;
   int dut_upd = 0, dut_clr = 0, dut_err = 0;
   int exp_upd = 0, exp_clr = 0, exp_err = 0;
   bit settled = 1'b0;
   logic [7:0] first_rx;

   // display model: character grid, cursor and escape progress
   logic [7:0] mchr [2][16];
   int mrow, mcol, mst, mp1, mp2;

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] model_line(input int r);
      logic [127:0] v;
      for (int c = 0; c < 16; c++) v[127-8*c -: 8] = mchr[r][c];
      return v;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 2; r++) for (int c = 0; c < 16; c++) mchr[r][c] = 8'h20;
      mrow = 0; mcol = 0; mst = 0; mp1 = 0; mp2 = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      int d;
      d = int'(b) - 48;
      if (mst == 0) begin
         if (b == 8'h1B) mst = 1;
         else if (b >= 8'h20 && b <= 8'h7E) begin
            mchr[mrow][mcol] = b;
            exp_upd++;
            mcol++;
            if (mcol == 16) begin mcol = 0; mrow = 1 - mrow; end
         end
      end else if (mst == 1) begin
         if (b == 8'h5B) begin mst = 2; mp1 = 0; mp2 = 0; end
         else begin mst = 0; exp_err++; end
      end else begin
         if (d >= 0 && d <= 9) begin
            if (mst == 2) mp1 = (mp1 * 10 + d > 99) ? 99 : mp1 * 10 + d;
            else          mp2 = (mp2 * 10 + d > 99) ? 99 : mp2 * 10 + d;
         end else if (b == 8'h3B && mst == 2) mst = 3;
         else if (b == 8'h6A) begin model_reset(); exp_clr++; end
         else if (b == 8'h48) begin
            mrow = (mp1 >= 1) ? 1 : 0;
            mcol = (mp2 > 15) ? 15 : mp2;
            mst = 0;
         end else begin mst = 0; exp_err++; end
      end
   endtask

   // shift n bits of b MSB-first, sampling CIPO just before each SCK rise
   task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
      rx = 8'd0;
      for (int i = 7; i > 7 - n; i--) begin
         copi = b[i];
         repeat (5) @(negedge clk);
         rx[i] = cipo;
         sck = 1'b1;
         repeat (5) @(negedge clk);
         sck = 1'b0;
      end
      if (n == 8) model_byte(b);
   endtask

   task automatic send_frame(input logic [127:0] data, input int len);
      logic [7:0] rx;
      settled = 1'b0;
      csn = 1'b0;
      repeat (5) @(negedge clk);
      for (int i = 0; i < len; i++) begin
         spi_bits(data[8*(len-1-i) +: 8], 8, rx);
         if (i == 0) first_rx = rx;
      end
      repeat (5) @(negedge clk);
      csn = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic checkpoint(input string tag);
      repeat (12) @(negedge clk);
      settled = 1'b1;
      repeat (2) @(negedge clk);
      check_int({tag, "_updates"}, dut_upd, exp_upd);
      check_int({tag, "_clears"}, dut_clr, exp_clr);
      check_int({tag, "_errs"}, dut_err, exp_err);
   endtask

   // compare process: pulse accounting every cycle, full state whenever the link is idle
   initial begin
      bit pu, pc, pe;
      pu = 1'b0; pc = 1'b0; pe = 1'b0;
      forever begin
         @(negedge clk);
         if (!srst) begin
            if (upd) begin dut_upd++; check_int("update_width", int'(pu), 0); end
            if (clr) begin dut_clr++; check_int("clear_width", int'(pc), 0); end
            if (err) begin dut_err++; check_int("err_width", int'(pe), 0); end
`ifndef PMOD_CLS_RESP_ECHO_EN
            check_int("cipo_tied", int'(cipo), 0);
`endif
            if (settled) begin
               check_vec("line1", line1, model_line(0));
               check_vec("line2", line2, model_line(1));
               check_int("row", int'(cur_row), mrow);
               check_int("col", int'(cur_col), mcol);
            end
         end
         pu = upd; pc = clr; pe = err;
      end
   end

   initial begin
      logic [7:0] rx;
      srst = 1'b1; sck = 1'b0; csn = 1'b1; copi = 1'b0;
      model_reset();
      repeat (5) @(negedge clk);
      srst = 1'b0;
      settled = 1'b1;
      repeat (4) @(negedge clk);
      check_vec("reset_line1", line1, {16{8'h20}});
      check_vec("reset_line2", line2, {16{8'h20}});
      check_int("reset_cursor", {cur_row, cur_col}, 0);
      check_int("reset_pulses", {upd, clr, err, cipo}, 0);

      // XY on line 1 then clear, all in one frame
      send_frame({8'h1B, 8'h5B, 8'h30, 8'h3B, 8'h30, 8'h30, 8'h48, 8'h58, 8'h59,
                  8'h1B, 8'h5B, 8'h30, 8'h6A}, 13);
      checkpoint("clear");
      check_int("clear_once", dut_clr, 1);
      check_int("xy_updates", dut_upd, 2);
      check_vec("clear_line1", line1, {16{8'h20}});

      send_frame({8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h30, 8'h30, 8'h48}, 7);
      send_frame("ABCDEFGHIJKLMNOP", 16);
      checkpoint("row2");
      check_vec("row2_text", line2, "ABCDEFGHIJKLMNOP");
      check_int("row2_updates", dut_upd, 18);
      check_int("row2_cursor", {cur_row, cur_col}, 0);

      // out-of-range cursor clamps to (1,15); the write then wraps to (0,0)
      send_frame({8'h1B, 8'h5B, 8'h39, 8'h3B, 8'h32, 8'h30, 8'h48, 8'h51}, 8);
      checkpoint("clamp");
      check_int("clamp_q", int'(line2[7:0]), 8'h51);
      check_int("clamp_cursor", {cur_row, cur_col}, 0);

      send_frame({8'h1B, 8'h5B, 8'h30, 8'h78, 8'h5A}, 5);
      checkpoint("badesc");
      check_int("badesc_err", dut_err, 1);
      check_int("badesc_z", int'(line1[127:120]), 8'h5A);

      // partial byte aborted by CSN, then a clean 'A'
      settled = 1'b0;
      csn = 1'b0;
      repeat (5) @(negedge clk);
      spi_bits(8'h41, 5, rx);
      repeat (5) @(negedge clk);
      csn = 1'b1;
      exp_err++;
      repeat (10) @(negedge clk);
      send_frame({8'h41}, 1);
      checkpoint("abort");
      check_int("abort_err", dut_err, 2);
      check_vec("abort_line1", line1, {"ZA", {14{8'h20}}});
      send_frame({8'h01}, 1);
      checkpoint("echo");
`ifdef PMOD_CLS_RESP_ECHO_EN
      check_int("echo_rx", int'(first_rx), 8'h41);
`endif

      // reset mid-escape and mid-byte: no pulse, escape forgotten
      settled = 1'b0;
      csn = 1'b0;
      repeat (5) @(negedge clk);
      spi_bits(8'h1B, 8, rx);
      spi_bits(8'h5B, 8, rx);
      spi_bits(8'h31, 3, rx);
      srst = 1'b1;
      csn = 1'b1;
      repeat (5) @(negedge clk);
      srst = 1'b0;
      model_reset();
      repeat (5) @(negedge clk);
      send_frame({8'h4B}, 1);
      send_frame({8'h1B, 8'h5B, 8'h39, 8'h39, 8'h39, 8'h3B, 8'h35, 8'h48, 8'h53,
                  8'h7F, 8'h0A}, 11);
      checkpoint("post_reset");
      check_int("post_reset_k", int'(line1[127:120]), 8'h4B);
      check_int("sat_s", int'(line2[87:80]), 8'h53);
      check_int("sat_cursor", {cur_row, cur_col}, 5'h16);
      check_int("post_reset_err", dut_err, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pmod_cls_emul_spi_resp.md
# pmod_cls_emul_spi_resp

SPI Mode 0 responder that emulates the Digilent PMOD CLS display on the far end of the CLS SPI link. It oversamples SCK/CSN/COPI in the system clock domain and assembles MSB-first bytes. It decodes the CLS escape sequences (clear display, cursor position) and printable text into a 2x16 character buffer. The block serves as the bench/loopback target for the CLS driver and exposes the buffer and event pulses for checking or for mirroring onto another display.

## Interface
- parm_sync_stages, 2, number of flip-flops in each SCK/CSN/COPI synchronizer chain (minimum 2).
- parm_param_max, 99, saturation value of each decimal escape parameter.
- i_ext_spi_clk_x  in  1  system clock; one clock, all logic on its rising edge.
- i_srst  in  1  reset, synchronous, active-high.
- i_sck  in  1  SPI clock from the master, idle low (Mode 0).
- i_csn  in  1  SPI chip select, active-low.
- i_copi  in  1  SPI data from the master.
- o_cipo  out  1  SPI data to the master.
- o_line1  out  128  row 0 text; column 0 in [127:120].
- o_line2  out  128  row 1 text; column 0 in [127:120].
- o_cursor_row  out  1  current cursor row.
- o_cursor_col  out  4  current cursor column.
- o_update  out  1  one-cycle pulse when a character is written.
- o_cmd_clear  out  1  one-cycle pulse when a clear command executes.
- o_err  out  1  one-cycle pulse on an unknown escape final byte or an aborted partial byte.

## Operation
- Synchronizers: i_sck, i_csn and i_copi each pass through a parm_sync_stages chain. An SCK rise/fall is detected from the last two synchronized SCK samples.
- Shifter: while synchronized CSN is low, each SCK rise shifts COPI into a 3-bit counter plus an 8-bit shift register, MSB first. The 8th rise produces a byte strobe. A CSN rise with a bit count of 1–7 discards the partial byte and pulses o_err. The bit count clears on every CSN rise.
- Parser FSM, advanced once per byte strobe. Parser state persists across CSN frames, because command and text arrive in separate frames.
  - ST_TEXT
    - 0x1B -> ST_ESC.
    - 0x20..0x7E: write the byte at the cursor, pulse o_update, advance the cursor.
    - Any other byte is ignored.
  - ST_ESC
    - 0x5B -> ST_PARAM1, with both params cleared to 0.
    - Any other byte -> ST_TEXT and pulse o_err.
  - ST_PARAM1 / ST_PARAM2
    - '0'..'9': param = param*10 + digit, saturating at parm_param_max (7-bit).
    - ';' in ST_PARAM1 -> ST_PARAM2.
    - 'j' -> clear.
    - 'H' -> cursor set.
    - Anything else -> ST_TEXT and pulse o_err.
- Clear: both lines become all 0x20, cursor becomes (0,0), o_cmd_clear pulses; the parser returns to ST_TEXT.
- Cursor set: row = min(param1, 1) and col = min(param2, 15); the parser returns to ST_TEXT.
- Cursor advance after a write:
  - col < 15: col + 1.
  - col = 15: col becomes 0 and row toggles.
- Reset values:
  - Lines all 0x20; cursor (0,0); parser ST_TEXT; shifter cleared.
  - o_update, o_cmd_clear, o_err and o_cipo all 0.
  - Reset mid-byte or mid-escape abandons it with no pulse.

## Timing
- Input constraint: SCK high and low phases must each last ≥ parm_sync_stages + 2 clock periods.
- Byte strobe: parm_sync_stages + 1 cycles after the raw 8th SCK rise.
- Parser outputs (buffer, cursor, pulses): registered; they update and pulse on the cycle after the byte strobe.
- Simultaneous events: a byte strobe and a CSN rise in the same cycle keep the complete byte, and no o_err is raised.
- o_cipo is registered and changes only on detected SCK falls or the CSN fall.

## Configuration
- PMOD_CLS_RESP_ECHO_EN defined: an echo register holds the last completed byte.
  - On the CSN fall, o_cipo drives its MSB.
  - Each SCK fall shifts out the next bit, so the master reads back the previous byte.
  - The echo register resets to 0x00.
- PMOD_CLS_RESP_ECHO_EN undefined: o_cipo is tied to 0 and no echo register exists.

## Test plan
- Reset with no stimulus -> o_line1 = o_line2 = 128'h2020…20, cursor (0,0), all pulses 0, o_cipo 0.
- Write line 1 "XY" via ESC[0;00H then 1B 5B 30 6A in one frame -> exactly one o_cmd_clear pulse; both lines back to all 0x20; cursor (0,0).
- Frame 1B 5B 31 3B 30 30 48, CSN high, then frame "ABCDEFGHIJKLMNOP" -> o_line2 = "ABCDEFGHIJKLMNOP"; 16 o_update pulses; cursor ends at (0,0).
- 1B 5B 39 3B 32 30 48 then 'Q' -> 'Q' lands in o_line2[7:0]; cursor ends at (0,0).
- 1B 5B 30 78 then 'Z' -> one o_err pulse; 'Z' written at the prior cursor position.
- CSN rises after 5 SCK bits, then the full byte 0x41 -> one o_err pulse, then 'A' written. With PMOD_CLS_RESP_ECHO_EN, the next frame reads back 0x41 on o_cipo.
